fft_frame_sequencer: RTL
========================

FFT_FRAME_SEQUENCER -- requirements
Module: fft_frame_sequencer

Interface
REQ-001 SHALL have parameter N, default 16, meaning FFT points per frame (power of two).
REQ-002 SHALL have parameter SIZE, default 4, meaning log2(N) and the address width.
REQ-003 SHALL have parameter TIMEOUT, default 1024, meaning the maximum cycles spent in RUN waiting for fft_done.
REQ-004 SHALL have port clk  input  1  system clock, all logic rising-edge.
REQ-005 SHALL have port rst_n  input  1  reset; one clock, synchronous, active-low.
REQ-006 SHALL have port start  input  1  begin a frame; accepted only in IDLE.
REQ-007 SHALL have port cont  input  1  continuous mode; sampled at end of DRAIN.
REQ-008 SHALL have port abort  input  1  synchronous return to IDLE.
REQ-009 SHALL have port in_valid  input  1  input sample strobe.
REQ-010 SHALL have port in_ready  output  1  sequencer accepts samples.
REQ-011 SHALL have port wr_en  output  1  sample RAM write enable.
REQ-012 SHALL have port wr_addr  output  SIZE  bit-reversed sample write address.
REQ-013 SHALL have port fft_start  output  1  one-cycle FFT core start pulse.
REQ-014 SHALL have port fft_done  input  1  FFT core completion pulse.
REQ-015 SHALL have port rd_en  output  1  result RAM read enable, 1-cycle read latency.
REQ-016 SHALL have port rd_addr  output  SIZE  natural-order result read address.
REQ-017 SHALL have port out_valid  output  1  result word present toward UART path.
REQ-018 SHALL have port out_ready  input  1  UART path accepts the word.
REQ-019 SHALL have port busy  output  1  high in every state except IDLE.
REQ-020 SHALL have port frame_done  output  1  one-cycle pulse after the last result is accepted.
REQ-021 SHALL have port frame_cnt  output  8  completed-frame counter, wraps 255->0.
REQ-022 SHALL have port timeout_err  output  1  sticky; FFT core failed to finish.

Function
REQ-023 SHALL implement states IDLE, LOAD, START, RUN and DRAIN.
REQ-024 SHALL transition IDLE->LOAD on start=1; start SHALL be ignored in all other states.
REQ-025 SHALL, in LOAD, drive in_ready=1 and wr_en=in_valid combinationally, with wr_addr=bit-reverse(sample count).
REQ-026 SHALL increment the sample count per accepted sample and go LOAD->START on the accepted sample with count N-1, resetting the count to 0.
REQ-027 SHALL drive in_ready=0 outside LOAD; in_valid outside LOAD SHALL cause no write.
REQ-028 SHALL assert fft_start for exactly the one cycle spent in START, then enter RUN.
REQ-029 SHALL, in RUN, go to DRAIN on fft_done=1; fft_done in any other state SHALL be ignored.
REQ-030 SHALL count RUN cycles and, when TIMEOUT cycles elapse without fft_done, set timeout_err and enter IDLE; if fft_done and the timeout coincide, fft_done SHALL win.
REQ-031 SHALL, in DRAIN, assert rd_en = (issued<N) && (!out_valid || out_ready), with rd_addr equal to the issue index 0..N-1 in increasing order.
REQ-032 SHALL set out_valid the cycle after rd_en and hold it until out_ready=1; with rd_en in the same cycle, out_valid SHALL stay high (back-to-back, no bubble).
REQ-033 SHALL, on the N-th accepted word (out_valid&&out_ready), pulse frame_done, increment frame_cnt, clear out_valid, and enter LOAD if cont=1, else IDLE.
REQ-034 SHALL, on abort=1 in any state, enter IDLE next cycle, clear counters, out_valid, rd_en, wr_en and fft_start, and leave frame_cnt unchanged; abort SHALL override start in the same cycle.

Reset
REQ-035 SHALL, while rst_n=0 at a clock edge, force IDLE and all counters to 0, and drive all outputs to 0, including timeout_err and frame_cnt.
REQ-036 SHALL honour reset mid-frame identically, with no residual writes, reads or pulses on the following cycle.

Verification
REQ-037 SHALL check: start, then 16 in_valid beats -> wr_addr sequence 0,8,4,12,2,...,15; single fft_start pulse one cycle after the 16th beat.
REQ-038 SHALL check: fft_done with out_ready=1 constantly -> 16 consecutive rd_en, rd_addr 0..15, 16 out_valid beats, frame_done pulse, frame_cnt=1, IDLE.
REQ-039 SHALL check: out_ready toggled randomly -> no rd_en while out_valid&&!out_ready, no lost or duplicated addresses.
REQ-040 SHALL check: fft_done withheld with TIMEOUT=1024 -> timeout_err=1 after 1024 RUN cycles, IDLE, frame_cnt unchanged.
REQ-041 SHALL check: cont=1 over 3 frames -> LOAD re-entered directly after DRAIN, frame_cnt=3; start pulses during frames have no effect.
REQ-042 SHALL check: abort at sample 7 of LOAD and rst_n=0 during DRAIN -> IDLE next cycle, all outputs 0, and a following frame completes normally.

Source files
------------

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: loads bit-reversed samples, starts and watches the FFT core, then drains results in order
module fft_frame_sequencer #(
  parameter int N = 16,
  parameter int SIZE = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            cont,
  input  logic            abort,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            wr_en,
  output logic [SIZE-1:0] wr_addr,
  output logic            fft_start,
  input  logic            fft_done,
  output logic            rd_en,
  output logic [SIZE-1:0] rd_addr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic            frame_done,
  output logic [7:0]      frame_cnt,
  output logic            timeout_err
);
  localparam int TW = $clog2(TIMEOUT) + 1;
  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [SIZE-1:0] cnt_q, cnt_d;
  logic [SIZE:0] issued_q, issued_d, acc_q, acc_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic out_valid_q, out_valid_d, frame_done_q, frame_done_d, timeout_err_q, timeout_err_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic accept, last;
  for (genvar i = 0; i < SIZE; i++) begin : g_rev
    assign wr_addr[i] = cnt_q[SIZE-1-i];
  end
  assign in_ready = state_q == LOAD;
  assign wr_en = in_ready && in_valid && !abort;
  assign fft_start = state_q == START;
  assign rd_en = state_q == DRAIN && issued_q < (SIZE+1)'(N) && (!out_valid_q || out_ready) && !abort;
  assign rd_addr = issued_q[SIZE-1:0];
  assign out_valid = out_valid_q;
  assign busy = state_q != IDLE;
  assign frame_done = frame_done_q;
  assign frame_cnt = frame_cnt_q;
  assign timeout_err = timeout_err_q;
  assign accept = out_valid_q && out_ready;
  assign last = state_q == DRAIN && accept && acc_q == (SIZE+1)'(N - 1);
  always_comb begin
    state_d = state_q;
    cnt_d = wr_en ? cnt_q + SIZE'(1) : cnt_q;
    issued_d = rd_en ? issued_q + (SIZE+1)'(1) : issued_q;
    acc_d = accept ? acc_q + (SIZE+1)'(1) : acc_q;
    tmo_d = state_q == RUN ? tmo_q + TW'(1) : '0;
    out_valid_d = rd_en || (out_valid_q && !out_ready);
    frame_done_d = last;
    frame_cnt_d = frame_cnt_q + 8'(last);
    timeout_err_d = timeout_err_q;
    if (state_q == IDLE && start) state_d = LOAD;
    if (wr_en && cnt_q == SIZE'(N - 1)) state_d = START;
    if (state_q == START) state_d = RUN;
    if (state_q == RUN && fft_done) state_d = DRAIN;
    if (state_q == RUN && !fft_done && tmo_q == TW'(TIMEOUT - 1)) begin
      state_d = IDLE;
      timeout_err_d = 1'b1;
    end
    if (last) begin
      state_d = cont ? LOAD : IDLE;
      issued_d = '0;
      acc_d = '0;
      out_valid_d = 1'b0;
    end
    if (abort) begin
      state_d = IDLE;
      cnt_d = '0;
      issued_d = '0;
      acc_d = '0;
      tmo_d = '0;
      out_valid_d = 1'b0;
      frame_done_d = 1'b0;
      frame_cnt_d = frame_cnt_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      issued_q <= '0;
      acc_q <= '0;
      tmo_q <= '0;
      out_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      issued_q <= issued_d;
      acc_q <= acc_d;
      tmo_q <= tmo_d;
      out_valid_q <= out_valid_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q <= frame_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end
endmodule
